// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch and a data requester,
// with starvation-bounded data priority, per-transaction timeout and a sticky error flag.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] iaddr,
    output logic [31:0] idata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic [31:0] daddr,
    input  logic [3:0]  we,
    input  logic [31:0] dwdata,
    output logic [31:0] drdata,
    output logic        d_ack,
    output logic        m_req,
    output logic [31:0] m_addr,
    output logic [3:0]  m_we,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        err
);
    localparam logic [1:0]  IDLE   = 2'd0;
    localparam logic [1:0]  BUSY_I = 2'd1;
    localparam logic [1:0]  BUSY_D = 2'd2;
    localparam logic [3:0]  SMAX   = 4'(STARVE_MAX);
    localparam logic [7:0]  TMAX   = 8'(TIMEOUT);
    localparam logic [31:0] NOP    = 32'h0000_0013;
    logic [1:0]  state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        armed_q, armed_d;
    logic        m_req_q, m_req_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [3:0]  m_we_q, m_we_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] idata_q, idata_d;
    logic [31:0] drdata_q, drdata_d;
    logic        err_q, err_d;
    logic        busy, pick_d, done;
    assign busy   = state_q != IDLE;
    assign pick_d = d_req && !(i_req && starve_q == SMAX);
    assign done   = busy && (m_ack || tmo_q + 8'd1 == TMAX);
    // armed_q holds off the first edge after reset release so no grant happens on it
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        tmo_d     = tmo_q;
        armed_d   = 1'b1;
        m_req_d   = m_req_q;
        m_addr_d  = m_addr_q;
        m_we_d    = m_we_q;
        m_wdata_d = m_wdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        idata_d   = idata_q;
        drdata_d  = drdata_q;
        err_d     = err_q;
        if (!busy && armed_q && (i_req || d_req)) begin
            state_d   = pick_d ? BUSY_D : BUSY_I;
            m_req_d   = 1'b1;
            m_addr_d  = pick_d ? daddr : iaddr;
            m_we_d    = pick_d ? we : 4'b0;
            m_wdata_d = pick_d ? dwdata : 32'b0;
            starve_d  = !pick_d ? 4'd0 : (i_req && starve_q != SMAX) ? starve_q + 4'd1 : starve_q;
            tmo_d     = 8'd0;
        end else if (done) begin
            state_d  = IDLE;
            m_req_d  = 1'b0;
            err_d    = err_q | !m_ack;
            i_ack_d  = state_q == BUSY_I;
            d_ack_d  = state_q != BUSY_I;
            idata_d  = state_q != BUSY_I ? idata_q : m_ack ? m_rdata : NOP;
            drdata_d = state_q == BUSY_I ? drdata_q : !m_ack ? 32'b0 : m_we_q == 4'b0 ? m_rdata : drdata_q;
        end else if (busy) begin
            tmo_d = tmo_q + 8'd1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            starve_q  <= 4'd0;
            tmo_q     <= 8'd0;
            armed_q   <= 1'b0;
            m_req_q   <= 1'b0;
            m_addr_q  <= 32'b0;
            m_we_q    <= 4'b0;
            m_wdata_q <= 32'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            idata_q   <= 32'b0;
            drdata_q  <= 32'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            tmo_q     <= tmo_d;
            armed_q   <= armed_d;
            m_req_q   <= m_req_d;
            m_addr_q  <= m_addr_d;
            m_we_q    <= m_we_d;
            m_wdata_q <= m_wdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            idata_q   <= idata_d;
            drdata_q  <= drdata_d;
            err_q     <= err_d;
        end
    end
    assign m_req   = m_req_q;
    assign m_addr  = m_addr_q;
    assign m_we    = m_we_q;
    assign m_wdata = m_wdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign idata   = idata_q;
    assign drdata  = drdata_q;
    assign err     = err_q;
endmodule
